// File: rtl/irq_pending_ctrl.sv
// -----------------------------------------------------------------------------
// irq_pending_ctrl
//
// Capture stage ahead of the 4-to-2 priority encoder. Each asynchronous request
// line is synchronised, optionally edge-detected and latched into a sticky
// pending register. The highest-priority unmasked pending bit is offered as a
// 2-bit code on a valid/ready handshake. Accepting a code clears its pending
// bit.
//
// Parameters
//   SYNC_STAGES : flops per req_in synchroniser (legal range 2..3)
//   EDGE_MODE   : 1 = capture rising edges, 0 = capture levels
//
// Ports
//   clk        : single clock for all state
//   rst_n      : asynchronous active-low reset
//   req_in     : asynchronous requests, bit 3 highest priority
//   mask       : 1 = bit excluded from arbitration (still captured)
//   out_valid  : out_code holds a granted request
//   out_ready  : consumer accepts out_code
//   out_code   : index of the granted bit
//   pending    : current pending register
//   overflow   : sticky, an edge arrived on a bit already pending
//   clr_ovf    : synchronous clear of overflow
// -----------------------------------------------------------------------------
module irq_pending_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req_in,
   input  logic [3:0] mask,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_code,
   output logic [3:0] pending,
   output logic       overflow,
   input  logic       clr_ovf
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0][3:0] sync_q;
   logic [3:0] s;
   logic [3:0] s_prev;
   logic [3:0] cap;
   logic [3:0] clr;
   logic [3:0] eligible;
   logic [1:0] next_code;
   logic [1:0] code_d;
   logic       handshake;
   logic       ovf_set;

   // ---------------------------------------------------------------------------
   // Synchroniser chain and edge history
   // ---------------------------------------------------------------------------
   // NOTE: every flop here uses <= so that all stages sample the values from
   // before the edge; blocking assignments would collapse the chain to one flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         s_prev <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
         s_prev <= s;
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // s_prev resets to 0, so a request held through reset reads as a fresh edge.
   generate
      if (EDGE_MODE != 0) begin : g_edge
         assign cap     = s & ~s_prev;
         assign ovf_set = |(cap & pending & ~clr);
      end else begin : g_level
         assign cap     = s;
         assign ovf_set = 1'b0;
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Pending register and overflow
   // ---------------------------------------------------------------------------
   assign handshake = (state_q == PRESENT) && out_ready;
   assign clr       = handshake ? (4'b0001 << out_code) : 4'b0000;

   // Capture has priority over the grant clear on the same bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= 4'b0000;
         overflow <= 1'b0;
      end else begin
         pending  <= cap | (pending & ~clr);
         overflow <= ovf_set | (overflow & ~clr_ovf);
      end
   end

   // ---------------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------------
   assign eligible = pending & ~mask;

   always_comb begin
      casez (eligible)
         4'b1???: next_code = 2'b11;
         4'b01??: next_code = 2'b10;
         4'b001?: next_code = 2'b01;
         default: next_code = 2'b00;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Handshake FSM. The code is frozen on entry to PRESENT; the forced return to
   // IDLE after each grant lets the cleared pending bit settle before the next
   // arbitration.
   // ---------------------------------------------------------------------------
   // NOTE: defaults assigned first keep this block free of inferred latches.
   always_comb begin
      state_d = state_q;
      code_d  = out_code;
      case (state_q)
         IDLE: begin
            if (|eligible) begin
               code_d  = next_code;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         out_code <= 2'b00;
      end else begin
         state_q  <= state_d;
         out_code <= code_d;
      end
   end

   assign out_valid = (state_q == PRESENT);

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_pending_ctrl
//
// Directed bench for irq_pending_ctrl. A behavioural model (a delay queue for
// the synchroniser plus plain pending/grant bookkeeping) is compared against
// the DUT every cycle, and literal expectations at key points pin the model.
// -----------------------------------------------------------------------------
module tb_irq_pending_ctrl;

   localparam int SS   = 2;
   localparam int EDGE = 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req_in;
   logic [3:0] mask;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_code;
   logic [3:0] pending;
   logic       overflow;
   logic       clr_ovf;

   int n_pass  = 0;
   int n_total = 0;

   irq_pending_ctrl #(
      .SYNC_STAGES(SS),
      .EDGE_MODE  (EDGE)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_in   (req_in),
      .mask     (mask),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_code (out_code),
      .pending  (pending),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model
   // ---------------------------------------------------------------------------
   logic [3:0] hist[$];          // req_in samples taken at recent clock edges
   logic [3:0] m_pending = 4'b0;
   logic       m_busy    = 1'b0;
   logic [1:0] m_code    = 2'b0;
   logic       m_ovf     = 1'b0;

   task automatic model_step();
      int         n;
      logic [3:0] s_cur, s_old, cap, clr, elig;
      logic       take;
      logic [1:0] best;
      if (!rst_n) begin
         hist.delete();
         m_pending = 4'b0;
         m_busy    = 1'b0;
         m_code    = 2'b0;
         m_ovf     = 1'b0;
      end else begin
         n     = hist.size();
         s_cur = (n >= SS)     ? hist[n-SS]   : 4'b0;
         s_old = (n >= SS + 1) ? hist[n-SS-1] : 4'b0;
         cap   = (EDGE != 0) ? (s_cur & ~s_old) : s_cur;
         take  = m_busy && out_ready;
         clr   = take ? (4'b0001 << m_code) : 4'b0000;
         if ((EDGE != 0) && ((cap & m_pending & ~clr) != 4'b0)) m_ovf = 1'b1;
         else if (clr_ovf) m_ovf = 1'b0;
         elig = m_pending & ~mask;
         if (m_busy) begin
            if (out_ready) m_busy = 1'b0;
         end else if (elig != 4'b0) begin
            best = 2'b0;
            for (int i = 0; i < 4; i++) if (elig[i]) best = 2'(i);
            m_code = best;
            m_busy = 1'b1;
         end
         m_pending = cap | (m_pending & ~clr);
         hist.push_back(req_in);
         while (hist.size() > SS + 1) void'(hist.pop_front());
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_step();
   end

   // Per-cycle comparison, away from the active edge.
   initial forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1) begin
         check("cyc_valid",    8'(out_valid), 8'(m_busy));
         check("cyc_pending",  8'(pending),   8'(m_pending));
         check("cyc_overflow", 8'(overflow),  8'(m_ovf));
         if (m_busy) check("cyc_code", 8'(out_code), 8'(m_code));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------------------------------------------------------------------
   // Directed stimulus. After "cyc(k)" from the drive point we sit just after
   // edge k-1 counted from the drive.
   // ---------------------------------------------------------------------------
   initial begin
      rst_n     = 1'b0;
      req_in    = 4'b0;
      mask      = 4'b0;
      out_ready = 1'b1;
      clr_ovf   = 1'b0;
      cyc(3);
      check("rst_valid",    8'(out_valid), 8'h0);
      check("rst_pending",  8'(pending),   8'h0);
      check("rst_overflow", 8'(overflow),  8'h0);
      check("rst_code",     8'(out_code),  8'h0);
      rst_n = 1'b1;
      cyc(2);

      // Basic latency and single grant.
      req_in = 4'b0001;
      cyc(3);
      check("s1_pend_e2",  8'(pending),   8'h1);
      check("s1_valid_e2", 8'(out_valid), 8'h0);
      req_in = 4'b0;
      cyc(1);
      check("s1_valid_e3", 8'(out_valid), 8'h1);
      check("s1_code_e3",  8'(out_code),  8'h0);
      cyc(1);
      check("s1_pend_e4",  8'(pending),   8'h0);
      check("s1_valid_e4", 8'(out_valid), 8'h0);
      cyc(4);

      // Two simultaneous requests, back-pressure, then drain in priority order.
      out_ready = 1'b0;
      req_in    = 4'b0110;
      cyc(3);
      req_in = 4'b0;
      cyc(1);
      for (int k = 0; k < 5; k++) begin
         check("s2_hold_valid", 8'(out_valid), 8'h1);
         check("s2_hold_code",  8'(out_code),  8'h2);
         if (k < 4) cyc(1);
      end
      out_ready = 1'b1;
      cyc(1);
      check("s2_bubble_valid", 8'(out_valid), 8'h0);
      check("s2_bubble_pend",  8'(pending),   8'h2);
      cyc(1);
      check("s2_second_valid", 8'(out_valid), 8'h1);
      check("s2_second_code",  8'(out_code),  8'h1);
      cyc(1);
      check("s2_end_pend",  8'(pending),   8'h0);
      check("s2_end_valid", 8'(out_valid), 8'h0);
      cyc(3);

      // Higher-priority arrival does not alter a presented code.
      out_ready = 1'b0;
      req_in    = 4'b0001;
      cyc(4);
      check("s3_code0", 8'(out_code), 8'h0);
      req_in = 4'b1000;
      cyc(5);
      check("s3_pend_both", 8'(pending),   8'h9);
      check("s3_still_0",   8'(out_code),  8'h0);
      check("s3_still_val", 8'(out_valid), 8'h1);
      req_in    = 4'b0;
      out_ready = 1'b1;
      cyc(1);
      check("s3_pend_after", 8'(pending), 8'h8);
      cyc(1);
      check("s3_next_valid", 8'(out_valid), 8'h1);
      check("s3_next_code",  8'(out_code),  8'h3);
      cyc(1);
      check("s3_end_pend", 8'(pending), 8'h0);
      cyc(3);

      // Masking.
      mask   = 4'b1000;
      req_in = 4'b1010;
      cyc(3);
      check("s4_pend", 8'(pending), 8'ha);
      req_in = 4'b0;
      cyc(1);
      check("s4_code1", 8'(out_code), 8'h1);
      cyc(1);
      check("s4_pend_masked", 8'(pending), 8'h8);
      cyc(2);
      check("s4_no_grant", 8'(out_valid), 8'h0);
      check("s4_pend_held", 8'(pending),  8'h8);
      mask = 4'b0;
      cyc(1);
      check("s4_unmask_valid", 8'(out_valid), 8'h1);
      check("s4_unmask_code",  8'(out_code),  8'h3);
      cyc(1);
      check("s4_end_pend", 8'(pending), 8'h0);
      cyc(3);

      // Overflow set, set-beats-clear, then clear.
      out_ready = 1'b0;
      req_in    = 4'b0100;
      cyc(3);
      req_in = 4'b0;
      cyc(2);
      req_in = 4'b0100;
      cyc(3);
      check("s5_ovf_set",  8'(overflow), 8'h1);
      check("s5_pend",     8'(pending),  8'h4);
      check("s5_code",     8'(out_code), 8'h2);
      req_in = 4'b0;
      cyc(2);
      req_in = 4'b0100;
      cyc(2);
      check("s5_ovf_sticky", 8'(overflow), 8'h1);
      clr_ovf = 1'b1;
      cyc(1);
      check("s5_ovf_set_wins", 8'(overflow), 8'h1);
      cyc(1);
      check("s5_ovf_cleared", 8'(overflow), 8'h0);
      clr_ovf   = 1'b0;
      req_in    = 4'b0;
      out_ready = 1'b1;
      cyc(1);
      check("s5_drain_pend", 8'(pending), 8'h0);
      cyc(3);

      // Asynchronous reset mid-PRESENT, request held through reset.
      out_ready = 1'b0;
      req_in    = 4'b1010;
      cyc(4);
      check("s6_pend",  8'(pending),  8'ha);
      check("s6_code3", 8'(out_code), 8'h3);
      req_in = 4'b0010;
      cyc(1);
      #2;
      rst_n = 1'b0;
      #1;
      check("s6_async_valid", 8'(out_valid), 8'h0);
      check("s6_async_pend",  8'(pending),   8'h0);
      check("s6_async_ovf",   8'(overflow),  8'h0);
      cyc(2);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      cyc(3);
      check("s6_recap_pend",  8'(pending),   8'h2);
      check("s6_recap_valid", 8'(out_valid), 8'h0);
      cyc(1);
      check("s6_grant_valid", 8'(out_valid), 8'h1);
      check("s6_grant_code",  8'(out_code),  8'h1);
      cyc(1);
      check("s6_end_pend", 8'(pending), 8'h0);
      req_in = 4'b0;
      cyc(3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
